apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
Two-master APB arbiter that shares the single downstream APB path (target select psel 01 = register map, 10 = interconnect) between the SPI-side master (m0) and an internal master (m1, e.g. key loader).
- Round-robin arbitration, one registered transfer at a time.
- Fully registered downstream SETUP/ACCESS sequencing.
- Per-transfer pready watchdog.

Parameters:
ADDR_W, 20, address width
DATA_W, 16, data width
STRB_W, 2, byte-strobe width
TIMEOUT, 255, max ACCESS cycles waiting on downstream pready; 0 disables the watchdog

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
m0_psel, m1_psel  input  2  master target select; 00 idle, 01 regmap, 10 icn, 11 illegal
m0_penable, m1_penable  input  1  master access phase
m0_pwrite, m1_pwrite  input  1  master write
m0_pstrb, m1_pstrb  input  STRB_W  master strobes
m0_paddr, m1_paddr  input  ADDR_W  master address
m0_pwdata, m1_pwdata  input  DATA_W  master write data
m0_prdata, m1_prdata  output  DATA_W  read data returned to master
m0_pready, m1_pready  output  1  transfer-complete pulse to master
m0_pslverr, m1_pslverr  output  1  error, valid with pready
psel  output  2  downstream select
penable, pwrite  output  1  downstream control
pstrb  output  STRB_W  downstream strobes
paddr  output  ADDR_W  downstream address
pwdata  output  DATA_W  downstream write data
prdata  input  DATA_W  downstream read data
pready, pslverr  input  1  downstream response
grant  output  2  one-hot current owner (bit0 = m0)
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
Reset and registers:
- Reset is asynchronous. Every output goes to 0, FSM goes to IDLE, watchdog counter clears, last-grant pointer is set to m1 so m0 wins the first tie.
- All outputs are registered.

FSM:
- IDLE: downstream psel=0, penable=0, grant=0.
  - Request = mN_psel != 00.
  - Single requester wins.
  - Both requesting: the master not granted last wins.
  - Winner's psel/pwrite/pstrb/paddr/pwdata are latched and grant is set.
  - Winner psel=11: go to RESP with pslverr=1, prdata=0; no downstream activity.
  - Otherwise go to SETUP.
- SETUP: drive latched fields downstream, penable=0. Always go to ACCESS next cycle; counter cleared.
- ACCESS: penable=1, fields held stable.
  - pready=1: capture prdata/pslverr, go to RESP.
  - pready=0 with TIMEOUT!=0 and counter==TIMEOUT-1: abort. Capture prdata=0, pslverr=1; timeout_err pulses in the RESP cycle; go to RESP.
  - Otherwise increment counter.
- RESP: downstream psel/penable=0. Granted master gets mN_pready=1 for exactly one cycle with mN_prdata/mN_pslverr. Update last-grant pointer, clear grant, go to IDLE.

Timing and protocol rules:
- Latency: request sampled in IDLE at cycle T gives SETUP T+1, ACCESS T+2, and mN_pready at T+3 with a zero-wait target. Minimum 4 cycles per transfer.
- Masters stay in their access phase (psel/penable high, fields stable) until their pready pulse. Non-granted masters wait with pready=0.
- A master's pready is never asserted while the other master is granted.
- mN_prdata/mN_pslverr hold their value until that master's next response. The next response overwrites them.
- The granted master dropping psel mid-transfer is a protocol violation. The downstream transfer still completes and the response is pulsed anyway.
- A request present in the IDLE cycle after RESP is a new transfer. The previous response has no back-to-back bypass.
- The arbiter does not check penable at request time; only psel qualifies a request.
- Reset asserted mid-transfer aborts immediately. No response is delivered.

Test Plan:
- m0 write psel=01, paddr=0x00C1A, pwdata=0xA007, pstrb=11; target zero-wait -> psel=01/penable=0 at T+1, penable=1 at T+2, m0_pready=1 and m0_pslverr=0 at T+3, grant=01 from T+1 to T+3.
- m0 and m1 reads requested in the same cycle after reset; target returns 0x1234 then 0x5678 -> m0 served first with 0x1234, then m1 with 0x5678; m1_pready=0 throughout m0's transfer.
- Both masters requesting continuously for 6 transfers -> grants alternate m0,m1,m0,m1,m0,m1; each pready is a single-cycle pulse.
- TIMEOUT=4, target pready held 0 -> exactly 4 ACCESS cycles, then mN_pready=1, pslverr=1, prdata=0, timeout_err=1 for one cycle, downstream psel back to 0.
- m1_psel=11 -> downstream psel stays 00; m1_pready=1 with m1_pslverr=1 at T+1.
- reset_n pulsed low during ACCESS -> all outputs 0 immediately; after release, simultaneous requests are granted to m0 first.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Two-master APB arbiter sharing one downstream APB path.
//
// Arbitrates round-robin between m0 (SPI-side master) and m1 (internal master).
// Only one transfer is in flight at a time. The winner's fields are registered
// and replayed downstream as SETUP then ACCESS. A per-transfer watchdog aborts
// an ACCESS phase that waits too long on pready. All outputs are registered.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   mN_psel/penable/pwrite/pstrb/paddr/pwdata  master request (psel 01 regmap,
//                           10 icn, 11 illegal, 00 idle)
//   mN_prdata/pready/pslverr  response to master N; pready is a 1-cycle pulse
//   psel/penable/pwrite/pstrb/paddr/pwdata  downstream request
//   prdata/pready/pslverr   downstream response
//   grant                   one-hot current owner (bit0 = m0)
//   timeout_err             1-cycle pulse in the RESP cycle of a watchdog abort
module apb_master_arbiter #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned STRB_W  = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [STRB_W-1:0] m0_pstrb,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic [1:0]        m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [STRB_W-1:0] m1_pstrb,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic [1:0]        psel,
    output logic              penable,
    output logic              pwrite,
    output logic [STRB_W-1:0] pstrb,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned     CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit              WdogEn = (TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_q, last_d;      // 1: m1 was granted last
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] m0_prdata_q, m0_prdata_d, m1_prdata_q, m1_prdata_d;
    logic              m0_pready_q, m0_pready_d, m1_pready_q, m1_pready_d;
    logic              m0_pslverr_q, m0_pslverr_d, m1_pslverr_q, m1_pslverr_d;
    logic              timeout_err_q, timeout_err_d;

    logic              req0, req1, pick1;
    logic [1:0]        win_psel;
    logic              rsp_fire, rsp_err;
    logic [DATA_W-1:0] rsp_data;

    // penable is not used to qualify a request.
    logic unused_penable;
    assign unused_penable = m0_penable | m1_penable;

    assign req0     = |m0_psel;
    assign req1     = |m1_psel;
    // m1 wins when alone, or on a tie when m0 was served last.
    assign pick1    = req1 & (~req0 | ~last_q);
    assign win_psel = pick1 ? m1_psel : m0_psel;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        grant_d       = grant_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pstrb_d       = pstrb_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        m0_prdata_d   = m0_prdata_q;
        m1_prdata_d   = m1_prdata_q;
        m0_pslverr_d  = m0_pslverr_q;
        m1_pslverr_d  = m1_pslverr_q;
        m0_pready_d   = 1'b0;
        m1_pready_d   = 1'b0;
        timeout_err_d = 1'b0;
        rsp_fire      = 1'b0;
        rsp_err       = 1'b0;
        rsp_data      = '0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req0 || req1) begin
                    grant_d  = pick1 ? 2'b10 : 2'b01;
                    pwrite_d = pick1 ? m1_pwrite : m0_pwrite;
                    pstrb_d  = pick1 ? m1_pstrb : m0_pstrb;
                    paddr_d  = pick1 ? m1_paddr : m0_paddr;
                    pwdata_d = pick1 ? m1_pwdata : m0_pwdata;
                    if (win_psel == 2'b11) begin
                        // Illegal target: answer with an error, nothing goes downstream.
                        rsp_fire = 1'b1;
                        rsp_err  = 1'b1;
                        state_d  = StResp;
                    end else begin
                        psel_d  = win_psel;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = StAccess;
            end
            StAccess: begin
                if (pready) begin
                    rsp_fire  = 1'b1;
                    rsp_data  = prdata;
                    rsp_err   = pslverr;
                    psel_d    = 2'b00;
                    penable_d = 1'b0;
                    state_d   = StResp;
                end else if (WdogEn && (cnt_q == CntMax)) begin
                    rsp_fire      = 1'b1;
                    rsp_err       = 1'b1;
                    timeout_err_d = 1'b1;
                    psel_d        = 2'b00;
                    penable_d     = 1'b0;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Route the response to the owner of this transfer.
        if (rsp_fire) begin
            if (grant_d[1]) begin
                m1_pready_d  = 1'b1;
                m1_prdata_d  = rsp_data;
                m1_pslverr_d = rsp_err;
            end else begin
                m0_pready_d  = 1'b1;
                m0_prdata_d  = rsp_data;
                m0_pslverr_d = rsp_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            last_q        <= 1'b1;
            grant_q       <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pstrb_q       <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            m0_prdata_q   <= '0;
            m1_prdata_q   <= '0;
            m0_pready_q   <= 1'b0;
            m1_pready_q   <= 1'b0;
            m0_pslverr_q  <= 1'b0;
            m1_pslverr_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            grant_q       <= grant_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pstrb_q       <= pstrb_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            m0_prdata_q   <= m0_prdata_d;
            m1_prdata_q   <= m1_prdata_d;
            m0_pready_q   <= m0_pready_d;
            m1_pready_q   <= m1_pready_d;
            m0_pslverr_q  <= m0_pslverr_d;
            m1_pslverr_q  <= m1_pslverr_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign pstrb       = pstrb_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;
    assign m0_prdata   = m0_prdata_q;
    assign m1_prdata   = m1_prdata_q;
    assign m0_pready   = m0_pready_q;
    assign m1_pready   = m1_pready_q;
    assign m0_pslverr  = m0_pslverr_q;
    assign m1_pslverr  = m1_pslverr_q;

endmodule
